// File: rtl/sdram_fifo_ctrl.sv
// rtl/sdram_fifo_ctrl.sv - user word stream to SDRAM burst request bridge
//
// Buffers user writes in a write FIFO and issues fixed-length SDRAM write
// bursts. Once the first write burst completes, reads are allowed: SDRAM read
// bursts refill a read FIFO that the user drains with rd_en.
//
// Ports:
//   clk_50m, reset_n              clock, asynchronous active-low reset
//   wr_en/wr_data/wr_full         user write port
//   rd_en/rd_data/rd_empty        user read port (rd_data registered)
//   wr_min_addr/wr_max_addr       inclusive write address window
//   rd_min_addr/rd_max_addr       inclusive read address window
//   sdram_init_done               controller ready
//   sdram_wr_req/ack/addr/data    write burst handshake (data is FIFO head)
//   sdram_rd_req/ack/addr/data    read burst handshake
//   err_flag                      sticky misuse flag
//
// Build option: define SDRAM_FIFO_ERR_FLAG_EN to build err_flag detection;
// otherwise err_flag is tied low.

module sdram_fifo_buf #(
    parameter int W     = 16,
    parameter int DEPTH = 512
) (
    input  logic                     clk_50m,
    input  logic                     reset_n,
    input  logic                     push,
    input  logic [W-1:0]             push_data,
    input  logic                     pop,
    output logic [W-1:0]             head,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = DEPTH[AW:0];

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          full;
    logic          empty;
    logic          do_push;
    logic          do_pop;

    assign full  = (count == FULL_CNT);
    assign empty = (count == '0);

    // A pop frees the slot a same-cycle push needs, and a same-cycle push
    // supplies the word an empty pop needs, so push+pop never changes count.
    assign do_push = push && (!full || pop);
    assign do_pop  = pop && (!empty || push);

    // When empty, the word being pushed is presented straight through.
    assign head = empty ? push_data : mem[rd_ptr];

    always_ff @(posedge clk_50m) begin
        if (do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    always_ff @(posedge clk_50m or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            case ({do_push, do_pop})
                2'b10:   count <= count + (AW+1)'(1);
                2'b01:   count <= count - (AW+1)'(1);
                default: count <= count;
            endcase
        end
    end
endmodule

module sdram_fifo_ctrl #(
    parameter int DATA_W     = 16,
    parameter int ADDR_W     = 24,
    parameter int FIFO_DEPTH = 512,
    parameter int BURST_LEN  = 256
) (
    input  logic              clk_50m,
    input  logic              reset_n,
    input  logic              wr_en,
    input  logic [DATA_W-1:0] wr_data,
    output logic              wr_full,
    input  logic              rd_en,
    output logic [DATA_W-1:0] rd_data,
    output logic              rd_empty,
    input  logic [ADDR_W-1:0] wr_min_addr,
    input  logic [ADDR_W-1:0] wr_max_addr,
    input  logic [ADDR_W-1:0] rd_min_addr,
    input  logic [ADDR_W-1:0] rd_max_addr,
    input  logic              sdram_init_done,
    output logic              sdram_wr_req,
    input  logic              sdram_wr_ack,
    output logic [ADDR_W-1:0] sdram_wr_addr,
    output logic [DATA_W-1:0] sdram_wr_data,
    output logic              sdram_rd_req,
    input  logic              sdram_rd_ack,
    output logic [ADDR_W-1:0] sdram_rd_addr,
    input  logic [DATA_W-1:0] sdram_rd_data,
    output logic              err_flag
);
    localparam int CW = $clog2(FIFO_DEPTH) + 1;
    localparam int BW = $clog2(BURST_LEN);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_WR   = 2'd1;
    localparam logic [1:0] ST_RD   = 2'd2;

    logic [1:0]        state;
    logic [BW-1:0]     burst_cnt;
    logic              rd_allow;
    logic [CW-1:0]     wr_count;
    logic [CW-1:0]     rd_count;
    logic [DATA_W-1:0] rd_head;
    logic              wr_ack_ok;
    logic              rd_ack_ok;
    logic              burst_last;
    logic              wr_ready;
    logic              rd_space;
    logic              rd_pop;

    // Address registers are only trusted after the first burst end; before
    // that the window minimum is used directly, so the start address follows
    // the min inputs through and out of reset without an async load.
    logic              wr_loaded;
    logic              rd_loaded;
    logic [ADDR_W-1:0] wr_addr_q;
    logic [ADDR_W-1:0] rd_addr_q;

    function automatic logic [ADDR_W-1:0] next_addr(
        input logic [ADDR_W-1:0] cur,
        input logic [ADDR_W-1:0] lo,
        input logic [ADDR_W-1:0] hi
    );
        logic [ADDR_W-1:0] n;
        n = cur + ADDR_W'(BURST_LEN);
        if ((n + ADDR_W'(BURST_LEN - 1)) > hi) n = lo;
        return n;
    endfunction

    assign sdram_wr_addr = wr_loaded ? wr_addr_q : wr_min_addr;
    assign sdram_rd_addr = rd_loaded ? rd_addr_q : rd_min_addr;

    // Acks count only while the matching request is actually out.
    assign wr_ack_ok  = (state == ST_WR) && sdram_wr_req && sdram_wr_ack;
    assign rd_ack_ok  = (state == ST_RD) && sdram_rd_req && sdram_rd_ack;
    assign burst_last = (burst_cnt == BW'(BURST_LEN - 1));

    assign wr_full  = (wr_count == CW'(FIFO_DEPTH));
    assign rd_empty = (rd_count == '0);
    assign wr_ready = (wr_count >= CW'(BURST_LEN));
    assign rd_space = ((CW'(FIFO_DEPTH) - rd_count) >= CW'(BURST_LEN));
    assign rd_pop   = rd_en && (!rd_empty || rd_ack_ok);

    sdram_fifo_buf #(.W(DATA_W), .DEPTH(FIFO_DEPTH)) u_wr_fifo (
        .clk_50m   (clk_50m),
        .reset_n   (reset_n),
        .push      (wr_en),
        .push_data (wr_data),
        .pop       (wr_ack_ok),
        .head      (sdram_wr_data),
        .count     (wr_count)
    );

    sdram_fifo_buf #(.W(DATA_W), .DEPTH(FIFO_DEPTH)) u_rd_fifo (
        .clk_50m   (clk_50m),
        .reset_n   (reset_n),
        .push      (rd_ack_ok),
        .push_data (sdram_rd_data),
        .pop       (rd_en),
        .head      (rd_head),
        .count     (rd_count)
    );

    always_ff @(posedge clk_50m or negedge reset_n) begin
        if (!reset_n) begin
            rd_data <= '0;
        end else if (rd_pop) begin
            rd_data <= rd_head;
        end
    end

    always_ff @(posedge clk_50m or negedge reset_n) begin
        if (!reset_n) begin
            state        <= ST_IDLE;
            burst_cnt    <= '0;
            rd_allow     <= 1'b0;
            sdram_wr_req <= 1'b0;
            sdram_rd_req <= 1'b0;
            wr_loaded    <= 1'b0;
            rd_loaded    <= 1'b0;
            wr_addr_q    <= '0;
            rd_addr_q    <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    burst_cnt <= '0;
                    if (sdram_init_done) begin
                        if (wr_ready)                  state <= ST_WR;
                        else if (rd_allow && rd_space) state <= ST_RD;
                    end
                end
                ST_WR: begin
                    sdram_wr_req <= 1'b1;
                    if (wr_ack_ok) begin
                        burst_cnt <= burst_cnt + BW'(1);
                        if (burst_last) begin
                            sdram_wr_req <= 1'b0;
                            state        <= ST_IDLE;
                            rd_allow     <= 1'b1;
                            wr_loaded    <= 1'b1;
                            wr_addr_q    <= next_addr(sdram_wr_addr, wr_min_addr, wr_max_addr);
                        end
                    end
                end
                ST_RD: begin
                    sdram_rd_req <= 1'b1;
                    if (rd_ack_ok) begin
                        burst_cnt <= burst_cnt + BW'(1);
                        if (burst_last) begin
                            sdram_rd_req <= 1'b0;
                            state        <= ST_IDLE;
                            rd_loaded    <= 1'b1;
                            rd_addr_q    <= next_addr(sdram_rd_addr, rd_min_addr, rd_max_addr);
                        end
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

`ifdef SDRAM_FIFO_ERR_FLAG_EN
    always_ff @(posedge clk_50m or negedge reset_n) begin
        if (!reset_n) begin
            err_flag <= 1'b0;
        end else if ((wr_en && wr_full) || (rd_en && rd_empty) ||
                     (sdram_wr_ack && (wr_count == '0)) ||
                     (sdram_rd_ack && (rd_count == CW'(FIFO_DEPTH)))) begin
            err_flag <= 1'b1;
        end
    end
`else
    assign err_flag = 1'b0;
`endif
endmodule

// File: tb/tb_sdram_fifo_ctrl.sv
// tb/tb_sdram_fifo_ctrl.sv - directed self-checking bench for sdram_fifo_ctrl

module tb_sdram_fifo_ctrl;
    localparam int DW    = 16;
    localparam int AW    = 24;
    localparam int DEPTH = 512;
    localparam int BL    = 256;
    localparam int LIMIT = 2000;

`ifdef SDRAM_FIFO_ERR_FLAG_EN
    localparam logic ERR_EXP = 1'b1;
`else
    localparam logic ERR_EXP = 1'b0;
`endif

    logic          clk_50m;
    logic          reset_n;
    logic          wr_en;
    logic [DW-1:0] wr_data;
    logic          wr_full;
    logic          rd_en;
    logic [DW-1:0] rd_data;
    logic          rd_empty;
    logic [AW-1:0] wr_min_addr;
    logic [AW-1:0] wr_max_addr;
    logic [AW-1:0] rd_min_addr;
    logic [AW-1:0] rd_max_addr;
    logic          sdram_init_done;
    logic          sdram_wr_req;
    logic          sdram_wr_ack;
    logic [AW-1:0] sdram_wr_addr;
    logic [DW-1:0] sdram_wr_data;
    logic          sdram_rd_req;
    logic          sdram_rd_ack;
    logic [AW-1:0] sdram_rd_addr;
    logic [DW-1:0] sdram_rd_data;
    logic          err_flag;

    int checks = 0;
    int passed = 0;

    sdram_fifo_ctrl #(.DATA_W(DW), .ADDR_W(AW), .FIFO_DEPTH(DEPTH), .BURST_LEN(BL)) dut (
        .clk_50m         (clk_50m),
        .reset_n         (reset_n),
        .wr_en           (wr_en),
        .wr_data         (wr_data),
        .wr_full         (wr_full),
        .rd_en           (rd_en),
        .rd_data         (rd_data),
        .rd_empty        (rd_empty),
        .wr_min_addr     (wr_min_addr),
        .wr_max_addr     (wr_max_addr),
        .rd_min_addr     (rd_min_addr),
        .rd_max_addr     (rd_max_addr),
        .sdram_init_done (sdram_init_done),
        .sdram_wr_req    (sdram_wr_req),
        .sdram_wr_ack    (sdram_wr_ack),
        .sdram_wr_addr   (sdram_wr_addr),
        .sdram_wr_data   (sdram_wr_data),
        .sdram_rd_req    (sdram_rd_req),
        .sdram_rd_ack    (sdram_rd_ack),
        .sdram_rd_addr   (sdram_rd_addr),
        .sdram_rd_data   (sdram_rd_data),
        .err_flag        (err_flag)
    );

    initial clk_50m = 1'b0;
    always #10 clk_50m = ~clk_50m;

    task automatic apply_reset();
        reset_n      = 1'b0;
        wr_en        = 1'b0;
        wr_data      = '0;
        rd_en        = 1'b0;
        sdram_wr_ack = 1'b0;
        sdram_rd_ack = 1'b0;
        sdram_rd_data = '0;
        repeat (2) @(negedge clk_50m);
        reset_n = 1'b1;
        @(negedge clk_50m);
    endtask

    task automatic push_words(input int first, input int n);
        for (int i = 0; i < n; i++) begin
            wr_en   = 1'b1;
            wr_data = DW'(first + i);
            @(negedge clk_50m);
        end
        wr_en = 1'b0;
    endtask

    task automatic wait_wr_req(output int cyc);
        cyc = 0;
        while (sdram_wr_req !== 1'b1 && cyc < LIMIT) begin
            @(negedge clk_50m);
            cyc++;
        end
    endtask

    task automatic wait_rd_req(output int cyc);
        cyc = 0;
        while (sdram_rd_req !== 1'b1 && cyc < LIMIT) begin
            @(negedge clk_50m);
            cyc++;
        end
    endtask

    task automatic service_wr_burst(input logic [AW-1:0] exp_addr, input int first, input string name);
        int cyc;
        int bad;
        logic [DW-1:0] bad_got;
        logic [DW-1:0] bad_exp;
        bad = 0;
        bad_got = '0;
        bad_exp = '0;
        wait_wr_req(cyc);
        checks++;
        if (sdram_wr_req !== 1'b1) $display("FAIL %s wr_req_timeout: got %0b expected 1", name, sdram_wr_req);
        else passed++;
        checks++;
        if (sdram_wr_addr !== exp_addr) $display("FAIL %s wr_addr: got %0d expected %0d", name, sdram_wr_addr, exp_addr);
        else passed++;
        for (int i = 0; i < BL; i++) begin
            if (sdram_wr_data !== DW'(first + i)) begin
                if (bad == 0) begin
                    bad_got = sdram_wr_data;
                    bad_exp = DW'(first + i);
                end
                bad++;
            end
            sdram_wr_ack = 1'b1;
            @(negedge clk_50m);
        end
        sdram_wr_ack = 1'b0;
        checks++;
        if (bad != 0) $display("FAIL %s wr_data: %0d bad words, first got %0d expected %0d", name, bad, bad_got, bad_exp);
        else passed++;
        checks++;
        if (sdram_wr_req !== 1'b0) $display("FAIL %s wr_req_drop: got %0b expected 0", name, sdram_wr_req);
        else passed++;
    endtask

    task automatic service_rd_burst(input logic [AW-1:0] exp_addr, input int first, input string name);
        int cyc;
        wait_rd_req(cyc);
        checks++;
        if (sdram_rd_req !== 1'b1) $display("FAIL %s rd_req_timeout: got %0b expected 1", name, sdram_rd_req);
        else passed++;
        checks++;
        if (sdram_rd_addr !== exp_addr) $display("FAIL %s rd_addr: got %0d expected %0d", name, sdram_rd_addr, exp_addr);
        else passed++;
        for (int i = 0; i < BL; i++) begin
            sdram_rd_data = DW'(first + i);
            sdram_rd_ack  = 1'b1;
            @(negedge clk_50m);
            if ((i % 64) == 63 && i != BL - 1) begin
                sdram_rd_ack = 1'b0;
                @(negedge clk_50m);
            end
        end
        sdram_rd_ack = 1'b0;
        checks++;
        if (sdram_rd_req !== 1'b0) $display("FAIL %s rd_req_drop: got %0b expected 0", name, sdram_rd_req);
        else passed++;
    endtask

    task automatic test_reset();
        apply_reset();
        checks++;
        if (sdram_wr_req !== 1'b0) $display("FAIL reset_wr_req: got %0b expected 0", sdram_wr_req); else passed++;
        checks++;
        if (sdram_rd_req !== 1'b0) $display("FAIL reset_rd_req: got %0b expected 0", sdram_rd_req); else passed++;
        checks++;
        if (rd_data !== 16'd0) $display("FAIL reset_rd_data: got %0d expected 0", rd_data); else passed++;
        checks++;
        if (wr_full !== 1'b0) $display("FAIL reset_wr_full: got %0b expected 0", wr_full); else passed++;
        checks++;
        if (rd_empty !== 1'b1) $display("FAIL reset_rd_empty: got %0b expected 1", rd_empty); else passed++;
        checks++;
        if (err_flag !== 1'b0) $display("FAIL reset_err_flag: got %0b expected 0", err_flag); else passed++;
        checks++;
        if (sdram_wr_addr !== 24'd0) $display("FAIL reset_wr_addr: got %0d expected 0", sdram_wr_addr); else passed++;
        checks++;
        if (sdram_rd_addr !== 24'd2048) $display("FAIL reset_rd_addr: got %0d expected 2048", sdram_rd_addr); else passed++;
    endtask

    task automatic test_single_write();
        int cyc;
        push_words(1, BL);
        wait_wr_req(cyc);
        checks++;
        if (cyc != 2) $display("FAIL wr_req_latency: got %0d cycles expected 2", cyc); else passed++;
        service_wr_burst(24'd0, 1, "single");
        wait_rd_req(cyc);
        checks++;
        if (sdram_rd_req !== 1'b1) $display("FAIL rd_allow: got rd_req %0b expected 1", sdram_rd_req); else passed++;
    endtask

    task automatic test_read_path();
        int cyc;
        int bad;
        logic [DW-1:0] bad_got;
        logic [DW-1:0] bad_exp;
        bad = 0;
        bad_got = '0;
        bad_exp = '0;
        service_rd_burst(24'd2048, 1, "read1");
        checks++;
        if (rd_empty !== 1'b0) $display("FAIL rd_empty_after_burst: got %0b expected 0", rd_empty); else passed++;
        wait_rd_req(cyc);
        checks++;
        if (sdram_rd_addr !== 24'd2304) $display("FAIL rd_addr_advance: got %0d expected 2304", sdram_rd_addr); else passed++;
        for (int i = 0; i < BL; i++) begin
            rd_en = 1'b1;
            @(negedge clk_50m);
            if (rd_data !== DW'(i + 1)) begin
                if (bad == 0) begin
                    bad_got = rd_data;
                    bad_exp = DW'(i + 1);
                end
                bad++;
            end
        end
        rd_en = 1'b0;
        checks++;
        if (bad != 0) $display("FAIL rd_data_seq: %0d bad words, first got %0d expected %0d", bad, bad_got, bad_exp);
        else passed++;
        checks++;
        if (rd_empty !== 1'b1) $display("FAIL rd_empty_after_drain: got %0b expected 1", rd_empty); else passed++;
    endtask

    task automatic test_error_flag();
        checks++;
        if (err_flag !== 1'b0) $display("FAIL err_before: got %0b expected 0", err_flag); else passed++;
        rd_en = 1'b1;
        @(negedge clk_50m);
        rd_en = 1'b0;
        checks++;
        if (rd_data !== 16'd256) $display("FAIL rd_hold_empty: got %0d expected 256", rd_data); else passed++;
        checks++;
        if (err_flag !== ERR_EXP) $display("FAIL err_set: got %0b expected %0b", err_flag, ERR_EXP); else passed++;
        repeat (3) @(negedge clk_50m);
        checks++;
        if (err_flag !== ERR_EXP) $display("FAIL err_sticky: got %0b expected %0b", err_flag, ERR_EXP); else passed++;
    endtask

    task automatic test_addr_wrap_priority();
        int cyc;
        apply_reset();
        push_words(1, 2 * BL);
        checks++;
        if (wr_full !== 1'b1) $display("FAIL wr_full_set: got %0b expected 1", wr_full); else passed++;
        wr_en   = 1'b1;
        wr_data = 16'hdead;
        @(negedge clk_50m);
        wr_en = 1'b0;
        service_wr_burst(24'd0, 1, "wrap0");
        wait_wr_req(cyc);
        checks++;
        if (sdram_wr_req !== 1'b1 || sdram_rd_req !== 1'b0)
            $display("FAIL wr_priority: got wr_req %0b rd_req %0b expected 1 0", sdram_wr_req, sdram_rd_req);
        else passed++;
        push_words(513, BL);
        service_wr_burst(24'd256, 257, "wrap1");
        push_words(769, BL);
        service_wr_burst(24'd512, 513, "wrap2");
        push_words(1025, BL);
        service_wr_burst(24'd768, 769, "wrap3");
        service_wr_burst(24'd0, 1025, "wrap4");
        wait_rd_req(cyc);
        checks++;
        if (sdram_wr_req !== 1'b0 || sdram_rd_req !== 1'b1)
            $display("FAIL drained_no_wr: got wr_req %0b rd_req %0b expected 0 1", sdram_wr_req, sdram_rd_req);
        else passed++;
    endtask

    task automatic test_reset_mid_burst();
        int cyc;
        apply_reset();
        push_words(1, 2 * BL);
        service_wr_burst(24'd0, 1, "pre");
        wait_wr_req(cyc);
        checks++;
        if (sdram_wr_addr !== 24'd256) $display("FAIL mid_addr_before: got %0d expected 256", sdram_wr_addr); else passed++;
        for (int i = 0; i < 100; i++) begin
            sdram_wr_ack = 1'b1;
            @(negedge clk_50m);
        end
        sdram_wr_ack = 1'b0;
        reset_n = 1'b0;
        #1;
        checks++;
        if (sdram_wr_req !== 1'b0) $display("FAIL mid_wr_req: got %0b expected 0", sdram_wr_req); else passed++;
        checks++;
        if (rd_empty !== 1'b1 || wr_full !== 1'b0)
            $display("FAIL mid_fifos: got rd_empty %0b wr_full %0b expected 1 0", rd_empty, wr_full);
        else passed++;
        checks++;
        if (sdram_wr_addr !== 24'd0) $display("FAIL mid_wr_addr: got %0d expected 0", sdram_wr_addr); else passed++;
        @(negedge clk_50m);
        reset_n = 1'b1;
        repeat (5) @(negedge clk_50m);
        checks++;
        if (sdram_wr_req !== 1'b0) $display("FAIL mid_no_restart: got %0b expected 0", sdram_wr_req); else passed++;
        push_words(2000, BL);
        service_wr_burst(24'd0, 2000, "post");
    endtask

    initial begin
        wr_min_addr     = 24'd0;
        wr_max_addr     = 24'd1023;
        rd_min_addr     = 24'd2048;
        rd_max_addr     = 24'd4095;
        sdram_init_done = 1'b1;
        test_reset();
        test_single_write();
        test_read_path();
        test_error_flag();
        test_addr_wrap_priority();
        test_reset_mid_burst();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule
